// File: rtl/tlc_multiway_controller_if.sv
// Lamp/sensor bundle between the multiway traffic controller and its board wrapper.
interface tlc_multiway_controller_if #(
    parameter int unsigned N_WAYS = 2,
    parameter int unsigned WW     = 1
);
    logic [N_WAYS-1:0] sensor;
    logic              flash_en;
    logic [N_WAYS-1:0] green;
    logic [N_WAYS-1:0] yellow;
    logic [N_WAYS-1:0] red;
    logic [1:0]        phase;
    logic [WW-1:0]     active_way;

    // Wrapper side: drives demand and flash request, observes lamps
    modport master (
        output sensor, flash_en,
        input  green, yellow, red, phase, active_way
    );

    // Controller side
    modport slave (
        input  sensor, flash_en,
        output green, yellow, red, phase, active_way
    );
endinterface

// File: rtl/tlc_multiway_controller.sv
// Demand-actuated N-way traffic light controller with yellow, all-red clearance and night flash.
module tlc_multiway_controller #(
    parameter int unsigned N_WAYS      = 2,
    parameter int unsigned TW          = 13,
    parameter int unsigned T_GREEN_MIN = 2000,
    parameter int unsigned T_GREEN_MAX = 8000,
    parameter int unsigned T_YELLOW    = 1000,
    parameter int unsigned T_ALLRED    = 200,
    parameter int unsigned T_FLASH     = 500
) (
    input  logic clk,
    input  logic reset,
    tlc_multiway_controller_if.slave bus
);

    localparam int unsigned WW    = (N_WAYS > 2) ? $clog2(N_WAYS) : 1;
    localparam int unsigned T_LIM = (2 ** TW) - 1;
    localparam int          NW    = int'(N_WAYS);

    localparam logic [TW-1:0] C_GMIN_LAST = TW'(T_GREEN_MIN - 1);
    localparam logic [TW-1:0] C_GMAX_LAST = TW'(T_GREEN_MAX - 1);
    localparam logic [TW-1:0] C_Y_LAST    = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] C_AR_LAST   = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] C_FL_LAST   = TW'(T_FLASH - 1);

    // Parameter sanity: refuse to elaborate an unbuildable configuration
    if (N_WAYS < 2 || N_WAYS > 8) begin : g_bad_nways
        $fatal(1, "tlc_multiway_controller: N_WAYS must be 2..8");
    end
    if (TW < 1 || TW > 30) begin : g_bad_tw
        $fatal(1, "tlc_multiway_controller: TW out of range");
    end
    if (T_GREEN_MIN < 1 || T_GREEN_MIN > T_LIM || T_GREEN_MAX < 1 || T_GREEN_MAX > T_LIM ||
        T_YELLOW < 1 || T_YELLOW > T_LIM || T_ALLRED < 1 || T_ALLRED > T_LIM ||
        T_FLASH < 1 || T_FLASH > T_LIM) begin : g_bad_times
        $fatal(1, "tlc_multiway_controller: every T_* must be within 1..2^TW-1");
    end
    if (T_GREEN_MIN > T_GREEN_MAX) begin : g_bad_green
        $fatal(1, "tlc_multiway_controller: T_GREEN_MIN exceeds T_GREEN_MAX");
    end

    typedef enum logic [1:0] {
        PH_ALLRED = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10,
        PH_FLASH  = 2'b11
    } phase_e;

    phase_e            r_phase;
    logic [WW-1:0]     r_cur;
    logic [TW-1:0]     r_timer;
    logic              r_flash_bit;

    phase_e            w_phase_nxt;
    logic [WW-1:0]     w_cur_nxt;
    logic [TW-1:0]     w_timer_nxt;
    logic              w_flash_nxt;

    logic [N_WAYS-1:0] w_cur_onehot;
    logic [N_WAYS-1:0] w_rot;
    logic              w_other_req;
    logic              w_cur_req;
    int                w_sel;
    int                w_sum;
    logic [WW-1:0]     w_next_way;

    logic [N_WAYS-1:0] w_green;
    logic [N_WAYS-1:0] w_yellow;
    logic [N_WAYS-1:0] w_red;

    assign w_cur_onehot = N_WAYS'(1) << r_cur;
    assign w_other_req  = (|(bus.sensor & ~w_cur_onehot)) | bus.flash_en;
    assign w_cur_req    = |(bus.sensor & w_cur_onehot);

    // Round-robin pick: first requesting way after cur, wrapping back to cur; cur+1 if none
    always_comb begin
        w_rot = N_WAYS'({bus.sensor, bus.sensor} >> (32'(r_cur) + 32'd1));
        w_sel = 0;
        for (int j = N_WAYS - 1; j >= 0; j--) begin
            if (w_rot[j]) w_sel = j;
        end
        w_sum = int'(r_cur) + 1 + w_sel;
        if (w_sum >= NW) w_sum = w_sum - NW;
        w_next_way = WW'(w_sum);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase     <= PH_ALLRED;
            r_cur       <= WW'(N_WAYS - 1);
            r_timer     <= '0;
            r_flash_bit <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_cur       <= w_cur_nxt;
            r_timer     <= w_timer_nxt;
            r_flash_bit <= w_flash_nxt;
        end
    end

    // Next-state: phase sequencing, timer and way selection
    always_comb begin
        w_phase_nxt = r_phase;
        w_cur_nxt   = r_cur;
        w_timer_nxt = r_timer + TW'(1);
        w_flash_nxt = r_flash_bit;
        case (r_phase)
            PH_ALLRED: begin
                if (r_timer == C_AR_LAST) begin
                    w_timer_nxt = '0;
                    if (bus.flash_en) begin
                        w_phase_nxt = PH_FLASH;
                        w_flash_nxt = 1'b1;
                    end else begin
                        w_phase_nxt = PH_GREEN;
                        w_cur_nxt   = w_next_way;
                    end
                end
            end
            PH_GREEN: begin
                if (r_timer >= C_GMIN_LAST && w_other_req &&
                    (!w_cur_req || r_timer == C_GMAX_LAST)) begin
                    w_phase_nxt = PH_YELLOW;
                    w_timer_nxt = '0;
                end else if (r_timer == C_GMAX_LAST) begin
                    w_timer_nxt = r_timer;
                end
            end
            PH_YELLOW: begin
                if (r_timer == C_Y_LAST) begin
                    w_phase_nxt = PH_ALLRED;
                    w_timer_nxt = '0;
                end
            end
            PH_FLASH: begin
                if (!bus.flash_en) begin
                    w_phase_nxt = PH_ALLRED;
                    w_timer_nxt = '0;
                    w_flash_nxt = 1'b0;
                end else if (r_timer == C_FL_LAST) begin
                    w_timer_nxt = '0;
                    w_flash_nxt = ~r_flash_bit;
                end
            end
        endcase
    end

    // Lamp decode straight from the registered state
    always_comb begin
        w_green  = '0;
        w_yellow = '0;
        w_red    = '1;
        case (r_phase)
            PH_GREEN: begin
                w_green = w_cur_onehot;
                w_red   = ~w_cur_onehot;
            end
            PH_YELLOW: begin
                w_yellow = w_cur_onehot;
                w_red    = ~w_cur_onehot;
            end
            PH_FLASH: begin
                w_yellow = {N_WAYS{r_flash_bit}};
                w_red    = '0;
            end
            PH_ALLRED: ;
        endcase
    end

    assign bus.green      = w_green;
    assign bus.yellow     = w_yellow;
    assign bus.red        = w_red;
    assign bus.phase      = r_phase;
    assign bus.active_way = r_cur;

endmodule

// File: tb/tb_tlc_multiway_controller.sv
// Bench for tlc_multiway_controller: a 2-way and a 3-way instance with short timings.
module tb_tlc_multiway_controller;

    localparam int unsigned TW = 6;

    logic clk;
    logic rst_a;
    logic rst_b;

    tlc_multiway_controller_if #(.N_WAYS(2), .WW(1)) bus_a ();
    tlc_multiway_controller_if #(.N_WAYS(3), .WW(2)) bus_b ();

    tlc_multiway_controller #(
        .N_WAYS(2), .TW(TW), .T_GREEN_MIN(4), .T_GREEN_MAX(8),
        .T_YELLOW(2), .T_ALLRED(1), .T_FLASH(3)
    ) u_dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a)
    );

    tlc_multiway_controller #(
        .N_WAYS(3), .TW(TW), .T_GREEN_MIN(4), .T_GREEN_MAX(8),
        .T_YELLOW(2), .T_ALLRED(1), .T_FLASH(3)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        bit         rst;
        logic [7:0] sens;
        bit         fl;
        int         reps;
        logic [7:0] g;
        logic [7:0] y;
        logic [7:0] r;
        logic [1:0] ph;
        logic [7:0] way;
    } vec_t;

    typedef struct {
        int         dut;
        int         row;
        int         rep;
        logic [7:0] g;
        logic [7:0] y;
        logic [7:0] r;
        logic [1:0] ph;
        logic [7:0] way;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    task automatic v(input int dut, input bit rst, input logic [7:0] sens, input bit fl,
                     input int reps, input logic [7:0] g, input logic [7:0] y,
                     input logic [7:0] r, input logic [1:0] ph, input logic [7:0] way);
        vec_t e;
        e.dut = dut; e.rst = rst; e.sens = sens; e.fl = fl; e.reps = reps;
        e.g = g; e.y = y; e.r = r; e.ph = ph; e.way = way;
        vecs.push_back(e);
    endtask

    task automatic check_front();
        exp_t       e;
        logic [7:0] gg, gy, gr, gw;
        logic [1:0] gp;
        e = sb.pop_front();
        if (e.dut == 0) begin
            gg = 8'(bus_a.green); gy = 8'(bus_a.yellow); gr = 8'(bus_a.red);
            gp = bus_a.phase;     gw = 8'(bus_a.active_way);
        end else begin
            gg = 8'(bus_b.green); gy = 8'(bus_b.yellow); gr = 8'(bus_b.red);
            gp = bus_b.phase;     gw = 8'(bus_b.active_way);
        end
        n_tests++;
        if (gg !== e.g || gy !== e.y || gr !== e.r || gp !== e.ph || gw !== e.way) begin
            n_fail++;
            $display("FAIL vec dut%0d row%0d rep%0d: got g=%b y=%b r=%b ph=%b way=%0d, want g=%b y=%b r=%b ph=%b way=%0d",
                     e.dut, e.row, e.rep, gg, gy, gr, gp, gw, e.g, e.y, e.r, e.ph, e.way);
        end
    endtask

    // Bounded wait for the next green on the 2-way DUT, then measure how long it lasts
    task automatic measure_green(output int len, output int way, output bit ok);
        int guard;
        ok    = 1'b1;
        len   = 0;
        guard = 0;
        while (bus_a.phase != 2'b01 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (bus_a.phase != 2'b01) ok = 1'b0;
        way = int'(bus_a.active_way);
        while (bus_a.phase == 2'b01 && len < 100) begin
            len++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int  len;
        int  way;
        bit  ok;
        exp_t e;

        n_tests = 0;
        n_fail  = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.sensor = '0; bus_a.flash_en = 1'b0;
        bus_b.sensor = '0; bus_b.flash_en = 1'b0;

        // Phases: 0 ALLRED, 1 GREEN, 2 YELLOW, 3 FLASH
        // 2-way: reset, then green rests on way0 with no demand
        v(0,1,0,0, 2, 0,0,3,0,1);
        v(0,0,0,0, 1, 1,0,2,1,0);
        v(0,0,0,0,50, 1,0,2,1,0);
        // 2-way: competing demand on way1 gives minimum green
        v(0,1,0,0, 2, 0,0,3,0,1);
        v(0,0,0,0, 1, 1,0,2,1,0);
        v(0,0,2,0, 3, 1,0,2,1,0);
        v(0,0,2,0, 2, 0,1,2,2,0);
        v(0,0,2,0, 1, 0,0,3,0,0);
        v(0,0,2,0, 1, 2,0,1,1,1);
        v(0,0,2,0,20, 2,0,1,1,1);
        // 2-way: both sensors held gives max-out alternation, then reset mid-yellow
        v(0,1,3,0, 2, 0,0,3,0,1);
        v(0,0,3,0, 8, 1,0,2,1,0);
        v(0,0,3,0, 2, 0,1,2,2,0);
        v(0,0,3,0, 1, 0,0,3,0,0);
        v(0,0,3,0, 8, 2,0,1,1,1);
        v(0,0,3,0, 2, 0,2,1,2,1);
        v(0,0,3,0, 1, 0,0,3,0,1);
        v(0,0,3,0, 8, 1,0,2,1,0);
        v(0,0,3,0, 1, 0,1,2,2,0);
        v(0,1,3,0, 1, 0,0,3,0,1);
        v(0,0,0,0, 1, 1,0,2,1,0);
        v(0,0,0,0,10, 1,0,2,1,0);
        // 2-way: flash request during green way1, flash cadence, release
        v(0,1,0,0, 2, 0,0,3,0,1);
        v(0,0,0,0, 1, 1,0,2,1,0);
        v(0,0,2,0, 3, 1,0,2,1,0);
        v(0,0,2,0, 2, 0,1,2,2,0);
        v(0,0,2,0, 1, 0,0,3,0,0);
        v(0,0,2,0, 5, 2,0,1,1,1);
        v(0,0,0,1, 2, 0,2,1,2,1);
        v(0,0,0,1, 1, 0,0,3,0,1);
        v(0,0,0,1, 3, 0,3,0,3,1);
        v(0,0,0,1, 3, 0,0,0,3,1);
        v(0,0,0,1, 2, 0,3,0,3,1);
        v(0,0,2,0, 1, 0,0,3,0,1);
        v(0,0,2,0, 1, 2,0,1,1,1);
        // 3-way: sensor=110 skips way0 in round-robin order
        v(1,1,0,0, 2, 0,0,7,0,2);
        v(1,0,0,0, 1, 1,0,6,1,0);
        v(1,0,6,0, 3, 1,0,6,1,0);
        v(1,0,6,0, 2, 0,1,6,2,0);
        v(1,0,6,0, 1, 0,0,7,0,0);
        v(1,0,6,0, 8, 2,0,5,1,1);
        v(1,0,6,0, 2, 0,2,5,2,1);
        v(1,0,6,0, 1, 0,0,7,0,1);
        v(1,0,6,0, 8, 4,0,3,1,2);
        v(1,0,6,0, 2, 0,4,3,2,2);
        v(1,0,6,0, 1, 0,0,7,0,2);
        v(1,0,6,0, 8, 2,0,5,1,1);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].reps; k++) begin
                @(negedge clk);
                if (vecs[i].dut == 0) begin
                    rst_a = vecs[i].rst; rst_b = 1'b1;
                    bus_a.sensor = 2'(vecs[i].sens); bus_a.flash_en = vecs[i].fl;
                end else begin
                    rst_b = vecs[i].rst; rst_a = 1'b1;
                    bus_b.sensor = 3'(vecs[i].sens); bus_b.flash_en = vecs[i].fl;
                end
                e.dut = vecs[i].dut; e.row = i; e.rep = k;
                e.g = vecs[i].g; e.y = vecs[i].y; e.r = vecs[i].r;
                e.ph = vecs[i].ph; e.way = vecs[i].way;
                sb.push_back(e);
                @(posedge clk); #1;
                check_front();
            end
        end

        // Hand-written: measured green lengths under continuous demand on both ways
        @(negedge clk);
        rst_b = 1'b1; rst_a = 1'b1;
        bus_a.sensor = 2'b11; bus_a.flash_en = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 4; n++) begin
            measure_green(len, way, ok);
            n_tests++;
            if (!ok || len != 8 || way != (n % 2)) begin
                n_fail++;
                $display("FAIL maxout green%0d: got len=%0d way=%0d found=%0d, want len=8 way=%0d found=1",
                         n, len, way, ok, n % 2);
            end
        end

        // Hand-written: flash wins over pending demand at the all-red exit, then reset aborts flash
        @(negedge clk);
        bus_a.flash_en = 1'b1;
        begin
            int guard;
            guard = 0;
            while (bus_a.phase != 2'b11 && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
        end
        n_tests++;
        if (bus_a.phase !== 2'b11 || bus_a.yellow !== 2'b11 || bus_a.red !== 2'b00) begin
            n_fail++;
            $display("FAIL flash_entry: got ph=%b y=%b r=%b, want ph=11 y=11 r=00",
                     bus_a.phase, bus_a.yellow, bus_a.red);
        end
        @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus_a.phase !== 2'b00 || bus_a.red !== 2'b11 || bus_a.yellow !== 2'b00 ||
            bus_a.active_way !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_flash: got ph=%b r=%b y=%b way=%0d, want ph=00 r=11 y=00 way=1",
                     bus_a.phase, bus_a.red, bus_a.yellow, bus_a.active_way);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound so a stuck DUT cannot hang the run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tlc_multiway_controller.md
Name: tlc_multiway_controller

Overview:
Parametrised successor to the two-road traffic light controller. It drives N_WAYS approaches, each with its own vehicle sensor and its own green/yellow/red outputs. Green time is demand-actuated, bounded by a minimum and a maximum, and each green is followed by a yellow and an all-red clearance interval. A night flashing mode is included. The block sits directly under the top-level board wrapper; sensors arrive already synchronised and debounced.

Parameters:
N_WAYS, 2, number of approaches (2..8)
TW, 13, phase timer width in bits
T_GREEN_MIN, 2000, minimum green duration in cycles
T_GREEN_MAX, 8000, maximum green duration in cycles while other demand exists
T_YELLOW, 1000, yellow duration in cycles
T_ALLRED, 200, all-red clearance duration in cycles
T_FLASH, 500, flash half-period in cycles
Constraints: every T_* is between 1 and 2^TW-1, and T_GREEN_MIN <= T_GREEN_MAX. Elaboration fails otherwise. WW = max(1, clog2(N_WAYS)).

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high)
sensor  in  N_WAYS  demand per approach, level, bit i = way i
flash_en  in  1  night flashing mode request, level
green  out  N_WAYS  green lamp per way
yellow  out  N_WAYS  yellow lamp per way
red  out  N_WAYS  red lamp per way
phase  out  2  00 ALLRED, 01 GREEN, 10 YELLOW, 11 FLASH
active_way  out  WW  way currently owning green/yellow

Behaviour:
- Registered state is {phase, cur, timer[TW-1:0], flash_bit}. Lamp outputs are a combinational decode of the registered state; they change on the same edge as the state and add no extra latency.
- Reset (sampled at a clk edge): phase=ALLRED, cur=N_WAYS-1, timer=0, flash_bit=0. Outputs: green=0, yellow=0, red=all ones, active_way=N_WAYS-1. Reset mid-phase aborts the phase immediately at that edge.
- Timer increments every cycle and clears to 0 on every phase transition. Phase X with fixed length T lasts exactly T cycles, with the exit decided when timer==T-1.
- Lamp decode:
  - GREEN: green[cur]=1; red on all other ways.
  - YELLOW: yellow[cur]=1; red on all other ways.
  - ALLRED: all red.
  - FLASH: yellow=all flash_bit; green=0; red=0.
- Exactly one lamp per way is lit, except in FLASH when flash_bit=0 (all dark).
- ALLRED, exit at timer==T_ALLRED-1:
  - If flash_en=1, go to FLASH (flash_bit=1).
  - Otherwise go to GREEN with cur=next. next is the first way with sensor=1, searching cur+1, cur+2, ... cur (mod N_WAYS). If no sensor is set, next=(cur+1) mod N_WAYS.
- GREEN:
  - other_req = any sensor[j]=1 for j!=cur, OR flash_en=1.
  - For timer < T_GREEN_MIN-1: always stay.
  - For timer >= T_GREEN_MIN-1: go to YELLOW when other_req AND (sensor[cur]=0 OR timer==T_GREEN_MAX-1).
  - Timer saturates at T_GREEN_MAX-1; no wrap.
  - With no other_req, green rests indefinitely.
  - Green length with continuous competing demand is therefore in [T_GREEN_MIN, T_GREEN_MAX].
- YELLOW: go to ALLRED at timer==T_YELLOW-1. cur is unchanged.
- FLASH:
  - flash_bit toggles and timer clears each time timer==T_FLASH-1.
  - If flash_en=0 at any cycle, go to ALLRED next edge (timer=0, flash_bit=0). cur is unchanged.
- Sensor changes during YELLOW or ALLRED are ignored except at the ALLRED exit sample. No request latching: a pulse that is gone by the decision cycle is lost.
- If flash_en and other demand are both present, flash wins at the ALLRED exit.
- N_WAYS=2 with sensor=2'b11 continuously gives strict alternation 0,1,0,1 at max-out.

Test Plan:
- Use N_WAYS=2, TW=6, MIN=4, MAX=8, Y=2, AR=1, FL=3 unless stated.
- Reset held 2 cycles, sensor=0 → red=11 throughout. After release: 1 ALLRED cycle, then green=01 and active_way=0. Green rests with no further transitions for 50 cycles.
- In GREEN way0, sensor=10 from cycle 0 → green way0 lasts exactly 4 cycles, yellow way0 2 cycles, ALLRED 1 cycle, then green=10.
- sensor=11 held → each green lasts exactly 8 cycles (max-out). Sequence: G0 8, Y0 2, AR 1, G1 8, Y1 2, AR 1, repeating.
- N_WAYS=3, in GREEN way0, sensor=110 → next green is way1, then way2 (round-robin skip order), never way0 while sensor[0]=0.
- flash_en=1 during GREEN way1 after MIN → yellow, ALLRED, then yellow=all ones 3 cycles / all zeros 3 cycles. flash_en=0 → ALLRED 1 cycle, then normal GREEN selection from cur=1.
- reset pulsed during YELLOW → next edge: red=all ones, phase=00, timer=0. Then the post-reset sequence matches the first scenario.
